// File: rtl/hsv2rgb.sv
// hsv2rgb: iterative HSV (value=max, saturation=chroma, hue in degrees)
// to packed 15-bit RGB converter with a read/done/busy handshake.
// Ports: clk, res (async active-low), read, hue[8:0], saturation[4:0],
//        value[4:0], hue_invalid -> data[15:0], done, busy.
module hsv2rgb #(
    parameter int HUE_SECTOR = 60,
    parameter int HUE_FULL   = 360
) (
    input  logic        clk,
    input  logic        res,
    input  logic        read,
    input  logic [8:0]  hue,
    input  logic [4:0]  saturation,
    input  logic [4:0]  value,
    input  logic        hue_invalid,
    output logic [15:0] data,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SECTOR, S_MUL, S_DIV, S_MAP, S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  hue_q, hue_d;
    logic [4:0]  sat_q, sat_d;
    logic [4:0]  val_q, val_d;
    logic        inv_q, inv_d;
    logic [4:0]  max_q, max_d;
    logic [4:0]  min_q, min_d;
    logic [4:0]  c_q, c_d;
    logic [8:0]  h_q, h_d;
    logic [2:0]  sector_q, sector_d;
    logic [5:0]  f_q, f_d;
    logic [10:0] p_q, p_d;
    logic [4:0]  q_q, q_d;
    logic [4:0]  r_q, r_d;
    logic [4:0]  g_q, g_d;
    logic [4:0]  b_q, b_d;
    logic [15:0] data_q, data_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [4:0]  min_v;
    logic [4:0]  c_v;

    always_comb begin
        state_d  = state_q;
        hue_d    = hue_q;
        sat_d    = sat_q;
        val_d    = val_q;
        inv_d    = inv_q;
        max_d    = max_q;
        min_d    = min_q;
        c_d      = c_q;
        h_d      = h_q;
        sector_d = sector_q;
        f_d      = f_q;
        p_d      = p_q;
        q_d      = q_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        data_d   = data_q;
        done_d   = done_q;
        busy_d   = busy_q;
        // Chroma larger than value would give a negative min; clamp it.
        min_v    = (sat_q > val_q) ? 5'd0 : val_q - sat_q;
        c_v      = val_q - min_v;

        unique case (state_q)
            S_IDLE: begin
                if (read) begin
                    hue_d   = hue;
                    sat_d   = saturation;
                    val_d   = value;
                    inv_d   = hue_invalid;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                max_d    = val_q;
                min_d    = min_v;
                c_d      = c_v;
                sector_d = 3'd0;
                h_d      = (hue_q >= 9'(HUE_FULL)) ? hue_q - 9'(HUE_FULL)
                                                    : hue_q;
                if (inv_q || (c_v == 5'd0)) begin
                    r_d     = val_q;
                    g_d     = val_q;
                    b_d     = val_q;
                    state_d = S_OUT;
                end else begin
                    state_d = S_SECTOR;
                end
            end
            S_SECTOR: begin
                if (h_q >= 9'(HUE_SECTOR)) begin
                    h_d      = h_q - 9'(HUE_SECTOR);
                    sector_d = sector_q + 3'd1;
                end else begin
                    f_d     = h_q[5:0];
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d     = 11'(c_q) * 11'(f_q);
                q_d     = 5'd0;
                state_d = S_DIV;
            end
            S_DIV: begin
                // Restoring division by repeated subtraction.
                if (p_q >= 11'(HUE_SECTOR)) begin
                    p_d = p_q - 11'(HUE_SECTOR);
                    q_d = q_q + 5'd1;
                end else begin
                    state_d = S_MAP;
                end
            end
            S_MAP: begin
                unique case (sector_q)
                    3'd0: begin r_d = max_q;        g_d = min_q + q_q;  b_d = min_q;        end
                    3'd1: begin r_d = max_q - q_q;  g_d = max_q;        b_d = min_q;        end
                    3'd2: begin r_d = min_q;        g_d = max_q;        b_d = min_q + q_q;  end
                    3'd3: begin r_d = min_q;        g_d = max_q - q_q;  b_d = max_q;        end
                    3'd4: begin r_d = min_q + q_q;  g_d = min_q;        b_d = max_q;        end
                    3'd5: begin r_d = max_q;        g_d = min_q;        b_d = max_q - q_q;  end
                    default: begin r_d = max_q;     g_d = max_q;        b_d = max_q;        end
                endcase
                state_d = S_OUT;
            end
            S_OUT: begin
                data_d  = {1'b0, r_q, g_q, b_q};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= S_IDLE;
            hue_q    <= '0;
            sat_q    <= '0;
            val_q    <= '0;
            inv_q    <= 1'b0;
            max_q    <= '0;
            min_q    <= '0;
            c_q      <= '0;
            h_q      <= '0;
            sector_q <= '0;
            f_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hue_q    <= hue_d;
            sat_q    <= sat_d;
            val_q    <= val_d;
            inv_q    <= inv_d;
            max_q    <= max_d;
            min_q    <= min_d;
            c_q      <= c_d;
            h_q      <= h_d;
            sector_q <= sector_d;
            f_q      <= f_d;
            p_q      <= p_d;
            q_q      <= q_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_hsv2rgb.sv
// tb_hsv2rgb: directed self-checking bench for hsv2rgb.
// Hand-computed RGB vectors, handshake, latency and reset checks.
module tb_hsv2rgb;

    logic        clk;
    logic        res;
    logic        read;
    logic [8:0]  hue;
    logic [4:0]  saturation;
    logic [4:0]  value;
    logic        hue_invalid;
    logic [15:0] data;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    hsv2rgb dut (
        .clk        (clk),
        .res        (res),
        .read       (read),
        .hue        (hue),
        .saturation (saturation),
        .value      (value),
        .hue_invalid(hue_invalid),
        .data       (data),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a request at negedge; it is accepted on the next posedge.
    task automatic req(input logic [8:0] h, input logic [4:0] s,
                       input logic [4:0] v, input logic inv);
        @(negedge clk);
        hue = h; saturation = s; value = v; hue_invalid = inv;
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    // Count posedges after the accept edge until done; busy must hold.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run(input string tag, input logic [8:0] h,
                       input logic [4:0] s, input logic [4:0] v,
                       input logic inv, input logic [15:0] exp,
                       output int lat);
        logic bok;
        req(h, s, v, inv);
        wait_done(lat, bok);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_busy"}, {15'd0, bok}, 16'd1);
        chk({tag, "_data"}, data, exp);
        chk({tag, "_lat"}, {15'd0, lat <= 42}, 16'd1);
    endtask

    initial begin
        int lat;
        logic bok;
        res = 1'b0; read = 1'b0; hue = '0;
        saturation = '0; value = '0; hue_invalid = 1'b0;
        #12;
        chk("rst_data", data, 16'h0000);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        res = 1'b1;

        run("red",   9'd0,   5'd31, 5'd31, 1'b0, 16'h7C00, lat);
        run("green", 9'd120, 5'd31, 5'd31, 1'b0, 16'h03E0, lat);
        run("h359",  9'd359, 5'd31, 5'd31, 1'b0, 16'h7C01, lat);
        run("ramp",  9'd30,  5'd20, 5'd25, 1'b0, 16'h65E5, lat);
        run("wrap",  9'd400, 5'd31, 5'd31, 1'b0, 16'h7E80, lat);
        run("clamp", 9'd0,   5'd20, 5'd10, 1'b0, 16'h2800, lat);
        run("cyan",  9'd180, 5'd31, 5'd31, 1'b0, 16'h03FF, lat);
        run("blue",  9'd240, 5'd31, 5'd31, 1'b0, 16'h001F, lat);
        run("greyi", 9'd77,  5'd9,  5'd17, 1'b1, 16'h4631, lat);
        chk("greyi_lat2", 16'(lat), 16'd2);
        run("greys", 9'd200, 5'd0,  5'd17, 1'b0, 16'h4631, lat);
        chk("greys_lat2", 16'(lat), 16'd2);

        // Read while busy must be ignored.
        req(9'd30, 5'd20, 5'd25, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        hue = 9'd120; saturation = 5'd31; value = 5'd31;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        chk("bsy_done_lo", {15'd0, done}, 16'd0);
        chk("bsy_busy_hi", {15'd0, busy}, 16'd1);
        wait_done(lat, bok);
        chk("bsy_done", {15'd0, done}, 16'd1);
        chk("bsy_data", data, 16'h65E5);
        repeat (5) @(posedge clk);
        #1;
        chk("bsy_no_restart", {15'd0, busy}, 16'd0);
        chk("bsy_data_hold", data, 16'h65E5);

        // Reset in the middle of the division loop.
        req(9'd59, 5'd31, 5'd31, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        chk("mid_rst_data", data, 16'h0000);
        chk("mid_rst_done", {15'd0, done}, 16'd0);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        res = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_done", {15'd0, done}, 16'd0);
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        run("after_rst", 9'd59, 5'd31, 5'd31, 1'b0, 16'h7FC0, lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
